sector_cache_sequencer: RTL
===========================

# sector_cache_sequencer

Sequences one port of the 512-byte dual-port sector cache for whole-sector transfers. On command, it either drains all 512 bytes to a byte stream (cache → drive serializer) or fills all 512 bytes from a byte stream (host/SD loader → cache). It computes a 16-bit additive checksum and reports completion or abort. The other cache port stays free for the opposite side of the design.

## Interface
- SECTOR_BYTES, 512: bytes per transfer; power of two.
- ADDR_W, 9: cache address width, log2(SECTOR_BYTES).
- clk  in  1  single clock for all logic and the cache port driven here.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_dir  in  1  0 = drain (read cache), 1 = fill (write cache).
- cmd_ready  out  1  high only in IDLE.
- abort  in  1  cancel the active transfer.
- cache_addr  out  ADDR_W  cache port address.
- cache_din  out  8  cache write data.
- cache_wr_en  out  1  cache write strobe.
- cache_dout  in  8  cache read data; registered; valid 1 cycle after address.
- out_data  out  8  drain stream byte.
- out_valid  out  1  drain stream valid.
- out_last  out  1  marks byte SECTOR_BYTES-1.
- out_ready  in  1  drain stream ready.
- in_data  in  8  fill stream byte.
- in_valid  in  1  fill stream valid.
- in_ready  out  1  fill stream ready.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a transfer completes.
- aborted  out  1  one-cycle pulse when a transfer is aborted.
- checksum  out  16  sum of transferred bytes mod 2^16; held until next command accepted.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, FINISH.
- Reset: state IDLE, byte counter 0, checksum 0, cache_addr 0; all strobes/valids/pulses 0.
- IDLE: cmd_ready=1. On cmd_valid, clear counter and checksum. cmd_dir=0 → RD_ADDR; cmd_dir=1 → WR.
- RD_ADDR: present cache_addr=counter with cache_wr_en=0 for one cycle → RD_DATA.
- RD_DATA: latch cache_dout into out_data on entry. Then out_valid=1, held with stable data until out_ready.
  - On handshake, add out_data to checksum.
  - If counter==SECTOR_BYTES-1 → FINISH; else increment counter → RD_ADDR.
  - out_last = out_valid && counter==SECTOR_BYTES-1.
- WR: in_ready=1 unless abort. cache_addr=counter, cache_din=in_data, cache_wr_en = in_valid && in_ready (combinational).
  - Each accepted byte adds to checksum.
  - Last byte (counter==SECTOR_BYTES-1) → FINISH; else increment counter.
- FINISH: done=1 for this single cycle → IDLE.
- abort while busy (not FINISH): next state IDLE, aborted=1 for one cycle, done not pulsed, checksum reflects the bytes accepted so far.
  - In WR, in_ready is gated low during abort, so no write occurs.
  - In RD_DATA, out_valid drops the cycle after abort. This is the only permitted withdrawal of valid.
- abort in IDLE or FINISH: ignored.
- Counter wraps never; width ADDR_W, terminal compare at SECTOR_BYTES-1.
- Checksum width 16, byte zero-extended, overflow discarded.

## Timing
- Drain: 2 cycles per byte minimum (address bubble); a full sector with out_ready tied high takes 1024 cycles from command acceptance to FINISH, then done one cycle later.
- Fill: 1 byte per cycle; 512 cycles with in_valid tied high, then done in FINISH.
- cmd_ready is low from the cycle after acceptance until the cycle after done/aborted (back in IDLE).
- out_data, out_valid, done, aborted, checksum are registered; in_ready, cache_wr_en, cache_din, out_last are combinational from registered state and inputs.
- rst_n assertion mid-transfer returns all outputs to reset values immediately; no done or aborted pulse.

## Structure
- Shared package (sector_pkg): SECTOR_BYTES, ADDR_W defaults, state enum type, DIR_DRAIN/DIR_FILL constants.
- Sub-module sector_checksum16 (clear, add_en, byte in, 16-bit sum out) is natural and reusable by the fill/verify path; everything else stays flat.

## Test plan
- Fill pattern byte=addr[7:0] with in_valid high → 512 writes at addresses 0..511, done at cycle 513 after accept, checksum 0xFF00.
- Drain the same sector with out_ready high → bytes 0x00..0xFF twice, out_last only on byte 511, checksum 0xFF00, done once.
- Drain with random out_ready stalls → out_data stable while out_valid && !out_ready; byte order unchanged.
- Fill with random in_valid gaps → no cache_wr_en without in_valid; final cache contents match the sent bytes.
- Abort after 100 fill bytes → aborted pulse, no done, cache writes 0..99 only, checksum = sum of 100 bytes, cmd_ready high next cycle.
- rst_n low mid-drain → out_valid/busy 0 asynchronously; the next command starts from address 0.

Source files
------------

// File: rtl/sector_cache_sequencer_pkg.sv
// Shared definitions for the sector cache sequencer.
//   SECTOR_BYTES_DEF / ADDR_W_DEF : default sector size and cache address width
//   DIR_DRAIN / DIR_FILL          : cmd_dir encodings
//   state_e                       : sequencer state encoding
//   csum_add                      : 16-bit additive checksum step (byte zero-extended)
package sector_cache_sequencer_pkg;

  localparam int SECTOR_BYTES_DEF = 512;
  localparam int ADDR_W_DEF       = $clog2(SECTOR_BYTES_DEF);

  localparam logic DIR_DRAIN = 1'b0;
  localparam logic DIR_FILL  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR      = 3'd3,
    S_FINISH  = 3'd4
  } state_e;

  // Overflow out of bit 15 is discarded by the result width.
  function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [7:0] data);
    return sum + {8'h00, data};
  endfunction

endpackage

// File: rtl/sector_cache_sequencer_if.sv
// Bus bundle between the sector cache sequencer and its surroundings.
//   command   : cmd_valid, cmd_dir, cmd_ready, abort
//   cache port: cache_addr, cache_din, cache_wr_en, cache_dout (registered read, 1-cycle latency)
//   drain out : out_data, out_valid, out_last, out_ready
//   fill in   : in_data, in_valid, in_ready
//   status    : busy, done, aborted, checksum
// master = the sequencer, slave = the environment (cache, streams, command source).
interface sector_cache_sequencer_if #(
  parameter int ADDR_W = 9
);
  logic              cmd_valid;
  logic              cmd_dir;
  logic              cmd_ready;
  logic              abort;

  logic [ADDR_W-1:0] cache_addr;
  logic [7:0]        cache_din;
  logic              cache_wr_en;
  logic [7:0]        cache_dout;

  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;

  logic              busy;
  logic              done;
  logic              aborted;
  logic [15:0]       checksum;

  modport master (
    input  cmd_valid, cmd_dir, abort, cache_dout, out_ready, in_data, in_valid,
    output cmd_ready, cache_addr, cache_din, cache_wr_en, out_data, out_valid, out_last,
           in_ready, busy, done, aborted, checksum
  );

  modport slave (
    output cmd_valid, cmd_dir, abort, cache_dout, out_ready, in_data, in_valid,
    input  cmd_ready, cache_addr, cache_din, cache_wr_en, out_data, out_valid, out_last,
           in_ready, busy, done, aborted, checksum
  );

endinterface

// File: rtl/sector_cache_sequencer_checksum16.sv
// 16-bit additive checksum accumulator.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the sum (wins over add_en)
//   add_en     : add data to the sum this cycle
//   data       : byte to add, zero-extended
//   sum        : registered running sum mod 2^16
module sector_cache_sequencer_checksum16
  import sector_cache_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        add_en,
  input  logic [7:0]  data,
  output logic [15:0] sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= 16'h0000;
    end else if (clear) begin
      sum <= 16'h0000;
    end else if (add_en) begin
      sum <= csum_add(sum, data);
    end
  end

endmodule

// File: rtl/sector_cache_sequencer.sv
// Whole-sector transfer sequencer for one port of the dual-port sector cache.
// Drains a sector to a byte stream or fills it from a byte stream, summing every
// transferred byte into a 16-bit checksum.
//   clk, rst_n : clock, async active-low reset
//   bus        : sector_cache_sequencer_if.master (command, cache port, drain/fill streams, status)
//
// state     | meaning
// IDLE      | waiting for a command, cmd_ready high
// RD_ADDR   | cache_addr = counter, read in flight
// RD_DATA   | byte on out_data/out_valid until out_ready
// WR        | accept in stream bytes, write cache at counter
// FINISH    | done pulse, back to IDLE
module sector_cache_sequencer
  import sector_cache_sequencer_pkg::*;
#(
  parameter int SECTOR_BYTES = SECTOR_BYTES_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input logic clk,
  input logic rst_n,
  sector_cache_sequencer_if.master bus
);

  localparam logic [2:0] ST_IDLE    = 3'(S_IDLE);
  localparam logic [2:0] ST_RD_ADDR = 3'(S_RD_ADDR);
  localparam logic [2:0] ST_RD_DATA = 3'(S_RD_DATA);
  localparam logic [2:0] ST_WR      = 3'(S_WR);
  localparam logic [2:0] ST_FINISH  = 3'(S_FINISH);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SECTOR_BYTES - 1);

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [7:0]        hold_q;
  logic              rd_first;
  logic              out_valid_q;
  logic              done_q;
  logic              aborted_q;
  logic [15:0]       sum;

  logic              cmd_acc;
  logic              at_last;
  logic              active;
  logic              abort_hit;
  logic              rd_hs;
  logic              in_ready_c;
  logic              wr_en;
  logic [7:0]        out_data_c;
  logic [7:0]        add_byte;

  assign cmd_acc    = (state == ST_IDLE) && bus.cmd_valid;
  assign at_last    = (cnt == LAST_IDX);
  assign active     = (state == ST_RD_ADDR) || (state == ST_RD_DATA) || (state == ST_WR);
  assign abort_hit  = bus.abort && active;
  assign rd_hs      = (state == ST_RD_DATA) && out_valid_q && bus.out_ready;
  assign in_ready_c = (state == ST_WR) && !bus.abort;
  assign wr_en      = in_ready_c && bus.in_valid;

  // The cache output register already holds the addressed byte in the first
  // RD_DATA cycle; it is captured into hold_q so a stalled byte stays stable
  // even if the other cache port rewrites that location.
  assign out_data_c = rd_first ? bus.cache_dout : hold_q;
  assign add_byte   = rd_hs ? out_data_c : bus.in_data;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (bus.cmd_valid) state_nx = (bus.cmd_dir == DIR_FILL) ? ST_WR : ST_RD_ADDR;
      ST_RD_ADDR: state_nx = ST_RD_DATA;
      ST_RD_DATA: if (rd_hs) state_nx = at_last ? ST_FINISH : ST_RD_ADDR;
      ST_WR:      if (wr_en && at_last) state_nx = ST_FINISH;
      ST_FINISH:  state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
    if (abort_hit) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      hold_q      <= 8'h00;
      rd_first    <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state       <= state_nx;
      // Valid rises on entry to RD_DATA and falls on handshake or abort.
      out_valid_q <= (state_nx == ST_RD_DATA);
      rd_first    <= (state == ST_RD_ADDR) && (state_nx == ST_RD_DATA);
      done_q      <= (state_nx == ST_FINISH);
      aborted_q   <= abort_hit;
      if (rd_first) hold_q <= bus.cache_dout;
      if (cmd_acc) begin
        cnt <= '0;
      end else if (!abort_hit && (rd_hs || wr_en) && !at_last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A byte the consumer takes in the same cycle as abort still counts.
  sector_cache_sequencer_checksum16 u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cmd_acc),
    .add_en (rd_hs || wr_en),
    .data   (add_byte),
    .sum    (sum)
  );

  assign bus.cmd_ready   = (state == ST_IDLE);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.cache_addr  = cnt;
  assign bus.cache_din   = bus.in_data;
  assign bus.cache_wr_en = wr_en;
  assign bus.in_ready    = in_ready_c;
  assign bus.out_data    = out_data_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_valid_q && at_last;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.checksum    = sum;

endmodule
